// File: rtl/mips_pkg.sv
// mips_pkg: shared load/store types (access size, LSU state) and word geometry
package mips_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/store replication and load lane-select/extension
//   size      access size (00 byte, 01 half, 1x word)
//   off       byte offset within the word (already forced aligned by caller)
//   uns       zero-extend loads when 1, sign-extend when 0
//   wdata     raw store data; wdata_rep is the lane-replicated bus data
//   rdata     raw bus read data; rdata_ext is the extracted, extended load value
//   be        byte enables for the access
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic        is_byte, is_half;
    logic [31:0] sh;
    assign is_byte   = size == SZ_BYTE;
    assign is_half   = size == SZ_HALF;
    assign be        = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
    // Shift the addressed lane down to bit 0; halfword offsets are 0 or 2 only.
    assign sh        = rdata >> {off, 3'b000};
    assign rdata_ext = is_byte ? {{24{~uns & sh[7]}}, sh[7:0]}
                     : is_half ? {{16{~uns & sh[15]}}, sh[15:0]}
                     : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit bridging the datapath to a req/ready data-memory bus
//   clk, reset (async, active-low)
//   mem_read_i/mem_write_i/size_i/unsigned_i/addr_i/write_data_i : datapath request
//   stall_o, readdata_o, misalign_o                             : datapath response
//   bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o           : bus request (registered)
//   bus_rdata_i, bus_ready_i                                     : bus response
// Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned requests are flagged and
// dropped; otherwise the low address bits are forced to zero and the access proceeds.
module lsu
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       write_data_i,
    output logic              stall_o,
    output logic [31:0]       readdata_o,
    output logic              misalign_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ready_i
);
    if (DATA_W != 32) begin : g_bad_data_w
        $error("lsu: DATA_W must be 32");
    end
    lsu_state_t                      state;
    logic [1:0]                      size_r, size_sel;
    logic [$clog2(WORD_BYTES)-1:0]   off_in, off_r, off_sel;
    logic                            uns_r, req, is_half, is_word, mis, legal, start;
    logic [3:0]                      be;
    logic [31:0]                     wdata_rep, rdata_ext;
    assign req     = mem_read_i | mem_write_i;
    assign is_half = size_i == SZ_HALF;
    assign is_word = size_i[1];
    assign mis     = (is_half & addr_i[0]) | (is_word & |addr_i[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign legal      = ~mis;
    assign misalign_o = state == IDLE && req && mis;
`else
    assign legal      = 1'b1;
    assign misalign_o = 1'b0;
`endif
    // Forcing the offending bits to zero is harmless when trapping, since
    // only aligned accesses get through in that build.
    assign off_in    = is_word ? 2'b00 : is_half ? {addr_i[1], 1'b0} : addr_i[1:0];
    assign start     = state == IDLE && req && legal;
    assign stall_o   = start || state == BUSY;
    assign bus_req_o = state == BUSY;
    // One alignment unit: it sees the live request in IDLE (store lanes)
    // and the registered access afterwards (load extraction).
    assign size_sel  = state == IDLE ? size_i : size_r;
    assign off_sel   = state == IDLE ? off_in : off_r;
    lsu_align u_align (
        .size      (size_sel),
        .off       (off_sel),
        .uns       (uns_r),
        .wdata     (write_data_i),
        .rdata     (bus_rdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= 32'h0;
            readdata_o  <= 32'h0;
            size_r      <= 2'b00;
            off_r       <= 2'b00;
            uns_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= BUSY;
                    bus_we_o    <= mem_write_i;
                    bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                    bus_be_o    <= be;
                    bus_wdata_o <= wdata_rep;
                    size_r      <= size_i;
                    off_r       <= off_in;
                    uns_r       <= unsigned_i;
                end
                BUSY: if (bus_ready_i) begin
                    state <= DONE;
                    if (!bus_we_o) readdata_o <= rdata_ext;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a byte-level behavioural model and literal checks
module tb_lsu;
    logic        clk = 0, reset = 0;
    logic        mem_read_i = 0, mem_write_i = 0, unsigned_i = 0, bus_ready_i = 0;
    logic [1:0]  size_i = 0;
    logic [31:0] addr_i = 0, write_data_i = 0, bus_rdata_i = 0;
    logic        stall_o, misalign_o, bus_req_o, bus_we_o;
    logic [31:0] readdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    int vectors = 0, miscompares = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1;
`else
    localparam bit TRAP = 0;
`endif
    lsu dut (
        .clk(clk), .reset(reset), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .write_data_i(write_data_i),
        .stall_o(stall_o), .readdata_o(readdata_o), .misalign_o(misalign_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // ---- behavioural model: transaction phase plus byte-lane arithmetic ----
    function automatic int nbytes(input logic [1:0] s);
        return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
    endfunction
    function automatic logic [3:0] be_of(input int off, input int n);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + n);
        return b;
    endfunction
    function automatic logic [31:0] rep(input logic [31:0] d, input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction
    function automatic logic [31:0] ext(input logic [31:0] d, input int off, input int n, input logic u);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = d[8*(off + k) +: 8];
        if (!u && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction
    function automatic bit aligned_now();
        return addr_i % nbytes(size_i) == 0;
    endfunction
    int          ph = 0, m_off = 0, m_n = 4;
    logic        m_we = 0, m_uns = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
    logic [3:0]  m_be = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph   <= 0;
            m_rd <= 0;
        end else if (ph == 0) begin
            if ((mem_read_i || mem_write_i) && (!TRAP || aligned_now())) begin
                ph     <= 1;
                m_n    <= nbytes(size_i);
                m_off  <= int'((addr_i & ~32'(nbytes(size_i) - 1)) % 4);
                m_addr <= addr_i & ~32'd3;
                m_we   <= mem_write_i;
                m_uns  <= unsigned_i;
                m_be   <= be_of(int'((addr_i & ~32'(nbytes(size_i) - 1)) % 4), nbytes(size_i));
                m_wd   <= rep(write_data_i, nbytes(size_i));
            end
        end else if (ph == 1) begin
            if (bus_ready_i) begin
                ph <= 2;
                if (!m_we) m_rd <= ext(bus_rdata_i, m_off, m_n, m_uns);
            end
        end else ph <= 0;
    end
    bit run = 0;
    always @(negedge clk) if (run) begin
        logic req, ok;
        req = mem_read_i || mem_write_i;
        ok  = !TRAP || aligned_now();
        chk("stall", 32'(stall_o), 32'((ph == 0 && req && ok) || ph == 1));
        chk("bus_req", 32'(bus_req_o), 32'(ph == 1));
        chk("misalign", 32'(misalign_o), 32'(TRAP && ph == 0 && req && !aligned_now()));
        chk("readdata", readdata_o, m_rd);
        if (ph == 1) begin
            chk("bus_we", 32'(bus_we_o), 32'(m_we));
            chk("bus_addr", bus_addr_o, m_addr);
            chk("bus_be", 32'(bus_be_o), 32'(m_be));
            chk("bus_wdata", bus_wdata_o, m_wd);
        end
    end
    // ---- directed access driver ----
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                             input int waits, output int stalls, output logic [3:0] be,
                             output logic [31:0] ba, output logic [31:0] bw, output logic bwe,
                             output logic [31:0] rdo);
        int busy = 0;
        bit seen = 0, done = 0;
        stalls = 0; be = 0; ba = 0; bw = 0; bwe = 0; rdo = 0;
        @(posedge clk); #1;
        mem_read_i = rd; mem_write_i = wr; size_i = sz; unsigned_i = u;
        addr_i = a; write_data_i = wd; bus_rdata_i = rdat; bus_ready_i = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus_req_o) begin
                busy++;
                if (busy == 1) begin be = bus_be_o; ba = bus_addr_o; bw = bus_wdata_o; bwe = bus_we_o; end
                bus_ready_i = busy > waits;
            end else bus_ready_i = 0;
            if (stall_o) begin stalls++; seen = 1; end
            else if (seen) begin done = 1; rdo = readdata_o; end
        end
        chk("access_completed", 32'(done), 32'd1);
        @(posedge clk); #1;
        mem_read_i = 0; mem_write_i = 0; bus_ready_i = 0;
    endtask
    int st; logic [3:0] be; logic [31:0] ba, bw, rdo; logic bwe;
    initial begin
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req_o), 0);
        chk("rst_bus_we", 32'(bus_we_o), 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_be", 32'(bus_be_o), 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        chk("rst_readdata", readdata_o, 0);
        chk("rst_misalign", 32'(misalign_o), 0);
        #2 reset = 1;
        run = 1;
        do_access(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, st, be, ba, bw, bwe, rdo);
        chk("lw_stalls", st, 2); chk("lw_be", 32'(be), 32'hF);
        chk("lw_addr", ba, 32'h100); chk("lw_data", rdo, 32'hDEADBEEF);
        do_access(1, 0, 2'b00, 0, 32'h203, 0, 32'h80FFFFFF, 0, st, be, ba, bw, bwe, rdo);
        chk("lb_data", rdo, 32'hFFFFFF80); chk("lb_be", 32'(be), 32'h8);
        do_access(1, 0, 2'b00, 1, 32'h203, 0, 32'h80FFFFFF, 0, st, be, ba, bw, bwe, rdo);
        chk("lbu_data", rdo, 32'h00000080);
        do_access(1, 1, 2'b10, 0, 32'h10, 32'h12345678, 32'hFFFFFFFF, 0, st, be, ba, bw, bwe, rdo);
        chk("rdwr_we", 32'(bwe), 1); chk("rdwr_readdata", rdo, 32'h00000080);
        do_access(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 0, 3, st, be, ba, bw, bwe, rdo);
        chk("sh_be", 32'(be), 32'hC); chk("sh_wdata", bw, 32'hABCDABCD); chk("sh_stalls", st, 5);
        do_access(1, 0, 2'b01, 0, 32'h102, 0, 32'h80011234, 1, st, be, ba, bw, bwe, rdo);
        chk("lh_data", rdo, 32'hFFFF8001); chk("lh_stalls", st, 3);
        do_access(0, 1, 2'b00, 0, 32'h21, 32'h000000A5, 0, 0, st, be, ba, bw, bwe, rdo);
        chk("sb_be", 32'(be), 32'h2); chk("sb_wdata", bw, 32'hA5A5A5A5);
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        mem_read_i = 1; size_i = 2'b10; addr_i = 32'h101;
        @(negedge clk);
        chk("mis_flag", 32'(misalign_o), 1); chk("mis_stall", 32'(stall_o), 0);
        chk("mis_req", 32'(bus_req_o), 0);
        @(negedge clk);
        chk("mis_req_later", 32'(bus_req_o), 0);
        @(posedge clk); #1 mem_read_i = 0;
`else
        do_access(1, 0, 2'b10, 0, 32'h101, 0, 32'h11223344, 0, st, be, ba, bw, bwe, rdo);
        chk("mis_addr", ba, 32'h100); chk("mis_data", rdo, 32'h11223344);
`endif
        // reset asserted while a load is waiting on the bus
        @(posedge clk); #1;
        mem_read_i = 1; size_i = 2'b10; addr_i = 32'h80; bus_ready_i = 0;
        @(negedge clk); @(negedge clk);
        chk("busy_before_reset", 32'(bus_req_o), 1);
        #2 reset = 0;
        #1;
        chk("reset_bus_req", 32'(bus_req_o), 0);
        chk("reset_readdata", readdata_o, 0);
        mem_read_i = 0;
        @(negedge clk); #3 reset = 1;
        do_access(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 0, st, be, ba, bw, bwe, rdo);
        chk("sw_stalls", st, 2); chk("sw_addr", ba, 32'h40);
        chk("sw_wdata", bw, 32'hCAFEF00D); chk("sw_we", 32'(bwe), 1);
        repeat (2) @(negedge clk);
        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
